// File: rtl/jtcop_layer_mixer.sv
// jtcop_layer_mixer
// -----------------------------------------------------------------------------
// N-layer pixel compositor for the cop video path. Each pixel-clock enable it
// takes one pixel per layer and finds the front-most opaque layer. The search
// order comes from a CPU-programmable priority list. The result is a palette
// address, the winning layer index and blanking delayed to match the pipeline.
//
// Pipeline (every stage advances only on i_pxl_cen, 3 pixels deep):
//   stage 1 : register pixels, blanking and per-layer opaque flags
//   stage 2 : reorder layers into priority-slot order (visible flag + pixel)
//   stage 3 : priority-encode the lowest visible slot into registered outputs
//
// Parameters:
//   LAYERS     number of input layers, 2..8
//   PXLW       bits per layer pixel {bank, colour}; low 4 bits = colour index
//   BLANK_ZERO when 1, o_pal_addr=0 and o_sel=8 while the delayed blank is active
//
// Optional feature macro: JTCOP_LAYER_MASK_EN
//   defined   : i_gfx_en[i]=0 makes layer i transparent at stage 1
//   undefined : i_gfx_en is ignored
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_pxl_cen         pixel clock enable
//   i_cpu_addr[3:1]   priority slot select
//   i_cpu_dout[15:0]  CPU write data, [2:0] = layer index for the slot
//   i_dsn[1:0]        data strobes, active low, only i_dsn[0] honoured
//   i_prio_cs         priority table write strobe
//   i_LHBL, i_LVBL    horizontal / vertical blank, active low
//   i_pxl             packed layer pixels, layer i at [i*PXLW +: PXLW]
//   i_gfx_en          per-layer debug enable
//   o_pal_addr        {layer index, winning pixel}
//   o_sel             winning layer index, 8 = backdrop
//   o_LHBL_dly        i_LHBL delayed 3 pixels
//   o_LVBL_dly        i_LVBL delayed 3 pixels
//
// Handshake: there is no valid/ready. A pixel is accepted on every clock with
// i_pxl_cen=1. Its result appears after the third such clock. Outputs hold
// their value between enables.
// -----------------------------------------------------------------------------
module jtcop_layer_mixer #(
  parameter int LAYERS     = 4,
  parameter int PXLW       = 8,
  parameter int BLANK_ZERO = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_pxl_cen,
  input  logic [3:1]             i_cpu_addr,
  input  logic [15:0]            i_cpu_dout,
  input  logic [1:0]             i_dsn,
  input  logic                   i_prio_cs,
  input  logic                   i_LHBL,
  input  logic                   i_LVBL,
  input  logic [LAYERS*PXLW-1:0] i_pxl,
  input  logic [LAYERS-1:0]      i_gfx_en,
  output logic [PXLW+2:0]        o_pal_addr,
  output logic [3:0]             o_sel,
  output logic                   o_LHBL_dly,
  output logic                   o_LVBL_dly
);

  // priority table: slot 0 is front-most
  logic [2:0]             r_prio [LAYERS];

  // stage 1
  logic [LAYERS*PXLW-1:0] r_s1_pxl;
  logic [LAYERS-1:0]      r_s1_opq;
  logic                   r_s1_hb, r_s1_vb;

  // stage 2, held in slot order
  logic [LAYERS-1:0]      r_s2_vis;
  logic [PXLW-1:0]        r_s2_pxl [LAYERS];
  logic [2:0]             r_s2_lay [LAYERS];
  logic                   r_s2_hb, r_s2_vb;

  // stage 3 / outputs
  logic [PXLW+2:0]        r_pal;
  logic [3:0]             r_sel;
  logic                   r_hb, r_vb;

  logic [LAYERS-1:0]      w_opq;
  logic [LAYERS-1:0]      w_vis;
  logic [PXLW-1:0]        w_cand [LAYERS];
  logic                   w_hit;
  logic [PXLW-1:0]        w_win_pxl;
  logic [2:0]             w_win_lay;
  logic                   w_blank;
  logic [PXLW+2:0]        w_pal_nx;
  logic [3:0]             w_sel_nx;
  logic                   w_unused;

  // A layer is opaque when its colour index is non-zero.
  always_comb begin
    for (int i = 0; i < LAYERS; i++) begin
`ifdef JTCOP_LAYER_MASK_EN
      w_opq[i] = (i_pxl[i*PXLW +: 4] != 4'd0) && i_gfx_en[i];
`else
      w_opq[i] = (i_pxl[i*PXLW +: 4] != 4'd0);
`endif
    end
  end

`ifdef JTCOP_LAYER_MASK_EN
  assign w_unused = &{1'b0, i_cpu_dout[15:3], i_dsn[1]};
`else
  assign w_unused = &{1'b0, i_cpu_dout[15:3], i_dsn[1], i_gfx_en};
`endif

  // Slot reordering. A slot whose table entry matches no layer (index >=
  // LAYERS) never matches below, so it stays invisible.
  always_comb begin
    for (int s = 0; s < LAYERS; s++) begin
      w_vis[s]  = 1'b0;
      w_cand[s] = '0;
      for (int j = 0; j < LAYERS; j++) begin
        if (r_prio[s] == 3'(j)) begin
          w_vis[s]  = r_s1_opq[j];
          w_cand[s] = r_s1_pxl[j*PXLW +: PXLW];
        end
      end
    end
  end

  // Lowest visible slot wins. Scanning downwards lets the lowest overwrite.
  always_comb begin
    w_hit     = 1'b0;
    w_win_pxl = '0;
    w_win_lay = '0;
    for (int s = LAYERS-1; s >= 0; s--) begin
      if (r_s2_vis[s]) begin
        w_hit     = 1'b1;
        w_win_pxl = r_s2_pxl[s];
        w_win_lay = r_s2_lay[s];
      end
    end
  end

  assign w_blank = !(r_s2_hb && r_s2_vb);

  always_comb begin
    w_pal_nx = '0;
    w_sel_nx = 4'd8;
    if (w_hit && !((BLANK_ZERO != 0) && w_blank)) begin
      w_pal_nx = {w_win_lay, w_win_pxl};
      w_sel_nx = {1'b0, w_win_lay};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int s = 0; s < LAYERS; s++) begin
        r_prio[s]   <= 3'(s);
        r_s2_pxl[s] <= '0;
        r_s2_lay[s] <= '0;
      end
      r_s1_pxl <= '0;
      r_s1_opq <= '0;
      r_s1_hb  <= 1'b0;
      r_s1_vb  <= 1'b0;
      r_s2_vis <= '0;
      r_s2_hb  <= 1'b0;
      r_s2_vb  <= 1'b0;
      r_pal    <= '0;
      r_sel    <= 4'd8;
      r_hb     <= 1'b0;
      r_vb     <= 1'b0;
    end else begin
      // Table writes ignore i_pxl_cen. A stage-2 sample in the same clock
      // still sees the old entry.
      if (i_prio_cs && !i_dsn[0]) begin
        for (int s = 0; s < LAYERS; s++) begin
          if (i_cpu_addr == 3'(s)) r_prio[s] <= i_cpu_dout[2:0];
        end
      end
      if (i_pxl_cen) begin
        r_s1_pxl <= i_pxl;
        r_s1_opq <= w_opq;
        r_s1_hb  <= i_LHBL;
        r_s1_vb  <= i_LVBL;
        r_s2_vis <= w_vis;
        for (int s = 0; s < LAYERS; s++) begin
          r_s2_pxl[s] <= w_cand[s];
          r_s2_lay[s] <= r_prio[s];
        end
        r_s2_hb  <= r_s1_hb;
        r_s2_vb  <= r_s1_vb;
        r_pal    <= w_pal_nx;
        r_sel    <= w_sel_nx;
        r_hb     <= r_s2_hb;
        r_vb     <= r_s2_vb;
      end
    end
  end

  assign o_pal_addr = r_pal;
  assign o_sel      = r_sel;
  assign o_LHBL_dly = r_hb;
  assign o_LVBL_dly = r_vb;

endmodule

// File: tb/tb_jtcop_layer_mixer.sv
// Bench for jtcop_layer_mixer (LAYERS=4, PXLW=8, BLANK_ZERO=1).
module tb_jtcop_layer_mixer;

  localparam int L = 4;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          pxl_cen = 1'b0;
  logic [2:0]    cpu_addr = '0;
  logic [15:0]   cpu_dout = '0;
  logic [1:0]    dsn = 2'b11;
  logic          prio_cs = 1'b0;
  logic          lhbl = 1'b0;
  logic          lvbl = 1'b0;
  logic [L*W-1:0] pxl = '0;
  logic [L-1:0]  gfx_en = '1;
  logic [W+2:0]  pal_addr;
  logic [3:0]    sel;
  logic          lhbl_dly, lvbl_dly;

  jtcop_layer_mixer #(.LAYERS(L), .PXLW(W), .BLANK_ZERO(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_pxl_cen(pxl_cen), .i_cpu_addr(cpu_addr),
    .i_cpu_dout(cpu_dout), .i_dsn(dsn), .i_prio_cs(prio_cs), .i_LHBL(lhbl),
    .i_LVBL(lvbl), .i_pxl(pxl), .i_gfx_en(gfx_en), .o_pal_addr(pal_addr),
    .o_sel(sel), .o_LHBL_dly(lhbl_dly), .o_LVBL_dly(lvbl_dly)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Keeps the table and the two pixels in flight. A pixel is resolved with
  // the table as it stands one enable after capture, then shown one enable later.
  typedef struct packed {
    logic [3:0]  sel;
    logic [10:0] pal;
    logic        hb;
    logic        vb;
  } res_t;

  typedef struct packed {
    logic [L*W-1:0] px;
    logic [L-1:0]   en;
    logic           hb;
    logic           vb;
  } smp_t;

  logic [2:0] m_tab [L];
  smp_t       m_s1;
  res_t       m_s2;
  res_t       m_out;

  function automatic res_t resolve(input smp_t s);
    res_t r;
    int   ly;
    bit   found;
    r.sel = 4'd8; r.pal = '0; r.hb = s.hb; r.vb = s.vb;
    found = 0;
    if (s.hb && s.vb) begin
      for (int k = 0; k < L; k++) begin
        ly = int'(m_tab[k]);
        if (!found && ly < L) begin
          bit on;
          on = (s.px[ly*W +: 4] != 4'd0);
`ifdef JTCOP_LAYER_MASK_EN
          on = on && s.en[ly];
`endif
          if (on) begin
            found = 1;
            r.sel = 4'(ly);
            r.pal = {3'(ly), s.px[ly*W +: W]};
          end
        end
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < L; k++) m_tab[k] = 3'(k);
    m_s1  = '0;
    m_s2  = '{sel: 4'd8, pal: 11'd0, hb: 1'b0, vb: 1'b0};
    m_out = m_s2;
  endtask

  // ---------------- driver ----------------
  // One clock. The model follows the inputs present at the edge, then all
  // four outputs are compared #1 after the edge.
  task automatic tick(input logic cen);
    pxl_cen = cen;
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else begin
      if (cen) begin
        m_out = m_s2;
        m_s2  = resolve(m_s1);
        m_s1  = '{px: pxl, en: gfx_en, hb: lhbl, vb: lvbl};
      end
      if (prio_cs && !dsn[0] && cpu_addr < 3'(L)) m_tab[cpu_addr] = cpu_dout[2:0];
    end
    pxl_cen = 1'b0;
    prio_cs = 1'b0;
    dsn     = 2'b11;
    check("model_sel", 16'(sel), 16'(m_out.sel));
    check("model_pal", 16'(pal_addr), 16'(m_out.pal));
    check("model_lhbl_dly", 16'(lhbl_dly), 16'(m_out.hb));
    check("model_lvbl_dly", 16'(lvbl_dly), 16'(m_out.vb));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0);
    rst = 1'b0;
  endtask

  task automatic wr(input logic [2:0] slot, input logic [2:0] val, input logic [1:0] d, input logic cen);
    cpu_addr = slot;
    cpu_dout = {13'($urandom), val};
    dsn      = d;
    prio_cs  = 1'b1;
    tick(cen);
  endtask

  task automatic cens(input int n);
    for (int k = 0; k < n; k++) tick(1'b1);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0] px;
    logic [3:0]  sel;
    logic [10:0] pal;
    string       name;
  } vec_t;

  vec_t vecs[3];
  localparam logic [31:0] ID_PX = 32'h21_32_43_54;

  initial begin
    vecs[0] = '{px: ID_PX,          sel: 4'd0, pal: 11'h054, name: "identity_l0"};
    vecs[1] = '{px: 32'h21_32_43_50, sel: 4'd1, pal: 11'h143, name: "l0_transparent"};
    vecs[2] = '{px: 32'h20_30_40_50, sel: 4'd8, pal: 11'h000, name: "all_transparent"};

    model_reset();
    rst = 1'b1;
    tick(1'b0);
    tick(1'b0);
    check("reset_sel", 16'(sel), 16'd8);
    check("reset_pal", 16'(pal_addr), 16'd0);
    check("reset_lhbl", 16'(lhbl_dly), 16'd0);
    rst = 1'b0;

    lhbl = 1'b1; lvbl = 1'b1;
    for (int v = 0; v < 3; v++) begin
      pxl = vecs[v].px;
      cens(3);
      check({vecs[v].name, "_sel"}, 16'(sel), 16'(vecs[v].sel));
      check({vecs[v].name, "_pal"}, 16'(pal_addr), 16'(vecs[v].pal));
    end

    // table reorder with dsn[0] active
    pxl = ID_PX;
    wr(3'd0, 3'd3, 2'b10, 1'b0);
    wr(3'd1, 3'd2, 2'b10, 1'b0);
    cens(3);
    check("reorder_sel", 16'(sel), 16'd3);
    check("reorder_pal", 16'(pal_addr), 16'h321);

    // dsn[0] inactive: writes ignored
    do_reset();
    wr(3'd0, 3'd3, 2'b01, 1'b0);
    wr(3'd1, 3'd2, 2'b01, 1'b0);
    cens(3);
    check("dsn_ignored_sel", 16'(sel), 16'd0);

    // invalid layer index in slot 0
    wr(3'd0, 3'd6, 2'b10, 1'b0);
    wr(3'd1, 3'd2, 2'b10, 1'b0);
    cens(3);
    check("invalid_slot_sel", 16'(sel), 16'd2);
    check("invalid_slot_pal", 16'(pal_addr), 16'h232);

    // slot addresses beyond the table are ignored
    wr(3'd6, 3'd1, 2'b10, 1'b0);
    cens(3);
    check("oob_addr_sel", 16'(sel), 16'd2);

    // duplicates, L2 transparent -> slot 3 (layer 3) wins
    wr(3'd0, 3'd2, 2'b10, 1'b0);
    pxl = 32'h21_30_43_54;
    cens(3);
    check("dup_sel", 16'(sel), 16'd3);
    check("dup_pal", 16'(pal_addr), 16'h321);

    // write in the same clock as an enable: the stage-2 sample uses the old entry
    do_reset();
    pxl = ID_PX;
    cens(3);
    wr(3'd0, 3'd1, 2'b10, 1'b1);
    tick(1'b1);
    check("same_cycle_old", 16'(sel), 16'd0);
    tick(1'b1);
    check("same_cycle_new", 16'(sel), 16'd1);

    // one-pixel LHBL pulse
    do_reset();
    pxl = ID_PX;
    cens(3);
    lhbl = 1'b0;
    tick(1'b1);
    lhbl = 1'b1;
    check("blank_n0", 16'(lhbl_dly), 16'd1);
    tick(1'b1);
    check("blank_n1", 16'(lhbl_dly), 16'd1);
    tick(1'b1);
    check("blank_n2_dly", 16'(lhbl_dly), 16'd0);
    check("blank_n2_pal", 16'(pal_addr), 16'd0);
    check("blank_n2_sel", 16'(sel), 16'd8);
    tick(1'b1);
    check("blank_n3_dly", 16'(lhbl_dly), 16'd1);
    check("blank_n3_pal", 16'(pal_addr), 16'h054);

    // hold with pxl_cen low while inputs change
    for (int k = 0; k < 5; k++) begin
      pxl = $urandom;
      lhbl = 1'($urandom);
      tick(1'b0);
    end
    check("hold_sel", 16'(sel), 16'd0);
    check("hold_pal", 16'(pal_addr), 16'h054);
    lhbl = 1'b1;

    // debug layer enable
    pxl = ID_PX;
    gfx_en = 4'b1110;
    cens(3);
`ifdef JTCOP_LAYER_MASK_EN
    check("gfx_en_sel", 16'(sel), 16'd1);
`else
    check("gfx_en_sel", 16'(sel), 16'd0);
`endif
    gfx_en = 4'b1111;

    // reset mid-line, with a reordered table
    wr(3'd0, 3'd3, 2'b10, 1'b0);
    cens(3);
    check("pre_rst_sel", 16'(sel), 16'd3);
    do_reset();
    check("mid_rst_sel", 16'(sel), 16'd8);
    check("mid_rst_pal", 16'(pal_addr), 16'd0);
    cens(3);
    check("post_rst_identity", 16'(sel), 16'd0);

    // randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      logic [31:0] r;
      for (int j = 0; j < L; j++) begin
        r[j*W +: W] = 8'($urandom);
        if ($urandom_range(0, 2) == 0) r[j*W +: 4] = 4'd0;
      end
      pxl    = r;
      lhbl   = ($urandom_range(0, 7) != 0);
      lvbl   = ($urandom_range(0, 15) != 0);
      gfx_en = 4'($urandom);
      if ($urandom_range(0, 99) == 0) do_reset();
      else if ($urandom_range(0, 5) == 0)
        wr(3'($urandom), 3'($urandom), 2'($urandom), 1'($urandom));
      else tick(1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
